// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state type and phase index constants for the phase sequencer.
package ctrl_pkg;
    typedef enum logic {IDLE, RUN} phase_state_t;
    localparam int PH_FETCH = 0;
endpackage

// File: rtl/rst_sync.sv
// rst_sync: shifts n_rst through an unreset flop chain and pulses on the release edge.
module rst_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic n_rst,
    output logic rel
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], n_rst};
    always_ff @(posedge clk) sync_q <= sync_d;
    // Oldest stage still low while the next one has seen the released reset.
    assign rel = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/phase_seq_gen.sv
// phase_seq_gen: one-hot instruction-phase sequencer with stall, early finish,
// single-step, halt/restart and a retired-instruction counter.
module phase_seq_gen
    import ctrl_pkg::*;
#(
    parameter int NPHASE      = 5,
    parameter int SYNC_STAGES = 3,
    parameter int AUTO_START  = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              hlt,
    input  logic              go,
    input  logic              step_mode,
    input  logic              stall,
    input  logic              fin,
    output logic [NPHASE-1:0] phase,
    output logic              cyc_start,
    output logic              running,
    output logic [CNT_W-1:0]  icount
);
    localparam logic [NPHASE-1:0] PH0 = NPHASE'(1) << PH_FETCH;
    phase_state_t      state_q, state_d;
    logic [NPHASE-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]  icount_q, icount_d;
    logic              rel, start, done;
    rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .rel   (rel)
    );
    assign start = ((AUTO_START != 0) && rel) || go;
    assign done  = fin | phase_q[NPHASE-1];
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        icount_d = icount_q;
        if (hlt) begin
            state_d = IDLE;
            phase_d = '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                phase_d = PH0;
            end
        end else if (!stall) begin
            if (done) begin
                icount_d = icount_q + CNT_W'(1);
                state_d  = step_mode ? IDLE : RUN;
                phase_d  = step_mode ? '0 : PH0;
            end else begin
                phase_d = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
            end
        end
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            icount_q <= icount_d;
        end
    end
    assign phase     = phase_q;
    assign running   = (state_q == RUN);
    assign cyc_start = phase_q[PH_FETCH] & ~stall;
    assign icount    = icount_q;
    a_phase_shape: assert property (@(posedge clk) disable iff (!n_rst)
        (state_q == RUN) ? $onehot(phase_q) : (phase_q == '0));
endmodule

// File: tb/tb_phase_seq_gen.sv
// tb_phase_seq_gen: vector table driven through a scoreboard, plus reset/restart sequences.
module tb_phase_seq_gen;
    localparam int SYNC = 3;
    logic clk = 0, n_rst = 0, hlt = 0, go = 0, step_mode = 0, stall = 0, fin = 0, go0 = 0;
    logic [4:0] phase, phase0;
    logic cyc_start, running, cyc0, run0;
    logic [15:0] icount, icount0;
    int checks = 0, errors = 0;
    typedef struct {logic hlt, go, step, stall, fin; logic [4:0] ph; logic run; logic [15:0] cnt;} vec_t;
    typedef struct {int idx; logic [4:0] ph; logic run; logic cyc; logic [15:0] cnt;} exp_t;
    vec_t vecs[$];
    exp_t sb[$];
    exp_t ce;
    always #5 clk = ~clk;
    phase_seq_gen #(.NPHASE(5), .SYNC_STAGES(SYNC), .AUTO_START(1), .CNT_W(16)) dut (
        .clk(clk), .n_rst(n_rst), .hlt(hlt), .go(go), .step_mode(step_mode), .stall(stall),
        .fin(fin), .phase(phase), .cyc_start(cyc_start), .running(running), .icount(icount)
    );
    phase_seq_gen #(.NPHASE(5), .SYNC_STAGES(SYNC), .AUTO_START(0), .CNT_W(16)) dut0 (
        .clk(clk), .n_rst(n_rst), .hlt(1'b0), .go(go0), .step_mode(1'b0), .stall(1'b0),
        .fin(1'b0), .phase(phase0), .cyc_start(cyc0), .running(run0), .icount(icount0)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    function automatic vec_t mk(input logic h, input logic g, input logic s, input logic st,
                                input logic f, input logic [4:0] p, input logic r, input logic [15:0] c);
        vec_t v;
        v.hlt = h; v.go = g; v.step = s; v.stall = st; v.fin = f; v.ph = p; v.run = r; v.cnt = c;
        return v;
    endfunction
    task automatic wait_start(input string name);
        int lat = 0;
        while (lat < SYNC + 1 && phase !== 5'b00001) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(name, 32'(phase), 32'd1);
        chk({name, "_run"}, 32'(running), 32'd1);
    endtask
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            ce = sb.pop_front();
            chk($sformatf("v%0d_phase", ce.idx), 32'(phase), 32'(ce.ph));
            chk($sformatf("v%0d_running", ce.idx), 32'(running), 32'(ce.run));
            chk($sformatf("v%0d_icount", ce.idx), 32'(icount), 32'(ce.cnt));
            chk($sformatf("v%0d_cyc_start", ce.idx), 32'(cyc_start), 32'(ce.cyc));
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        exp_t e;
        vecs.push_back(mk(0,0,0,0,0,5'b00010,1,0));
        vecs.push_back(mk(0,0,0,0,0,5'b00100,1,0));
        vecs.push_back(mk(0,0,0,0,0,5'b01000,1,0));
        vecs.push_back(mk(0,0,0,0,0,5'b10000,1,0));
        vecs.push_back(mk(0,0,0,0,0,5'b00001,1,1));
        vecs.push_back(mk(0,0,0,1,0,5'b00001,1,1));
        vecs.push_back(mk(0,0,0,0,0,5'b00010,1,1));
        vecs.push_back(mk(0,0,0,0,0,5'b00100,1,1));
        vecs.push_back(mk(0,0,0,1,0,5'b00100,1,1));
        vecs.push_back(mk(0,0,0,1,0,5'b00100,1,1));
        vecs.push_back(mk(0,0,0,1,0,5'b00100,1,1));
        vecs.push_back(mk(0,0,0,0,0,5'b01000,1,1));
        vecs.push_back(mk(0,0,0,0,0,5'b10000,1,1));
        vecs.push_back(mk(0,0,0,0,0,5'b00001,1,2));
        vecs.push_back(mk(0,0,0,0,0,5'b00010,1,2));
        vecs.push_back(mk(0,0,0,0,1,5'b00001,1,3));
        vecs.push_back(mk(0,0,0,0,0,5'b00010,1,3));
        vecs.push_back(mk(0,0,0,1,1,5'b00010,1,3));
        vecs.push_back(mk(0,0,0,0,0,5'b00100,1,3));
        vecs.push_back(mk(0,0,0,0,0,5'b01000,1,3));
        vecs.push_back(mk(1,0,0,0,0,5'b00000,0,3));
        vecs.push_back(mk(0,0,0,0,0,5'b00000,0,3));
        vecs.push_back(mk(0,0,0,1,0,5'b00000,0,3));
        vecs.push_back(mk(0,1,0,0,0,5'b00001,1,3));
        vecs.push_back(mk(0,0,0,0,1,5'b00001,1,4));
        vecs.push_back(mk(0,1,0,0,0,5'b00010,1,4));
        vecs.push_back(mk(1,1,0,0,0,5'b00000,0,4));
        vecs.push_back(mk(1,1,0,0,0,5'b00000,0,4));
        vecs.push_back(mk(0,1,1,0,0,5'b00001,1,4));
        vecs.push_back(mk(0,0,1,0,0,5'b00010,1,4));
        vecs.push_back(mk(0,0,1,0,0,5'b00100,1,4));
        vecs.push_back(mk(0,0,1,0,0,5'b01000,1,4));
        vecs.push_back(mk(0,0,1,0,0,5'b10000,1,4));
        vecs.push_back(mk(0,0,1,0,0,5'b00000,0,5));
        vecs.push_back(mk(0,0,1,0,0,5'b00000,0,5));
        vecs.push_back(mk(0,1,1,0,0,5'b00001,1,5));
        vecs.push_back(mk(0,0,1,0,0,5'b00010,1,5));
        vecs.push_back(mk(0,0,1,0,1,5'b00000,0,6));
        vecs.push_back(mk(0,1,0,0,0,5'b00001,1,6));
        vecs.push_back(mk(0,0,0,0,0,5'b00010,1,6));
        vecs.push_back(mk(0,0,0,0,0,5'b00100,1,6));
        vecs.push_back(mk(0,0,0,0,0,5'b01000,1,6));
        vecs.push_back(mk(0,0,0,0,0,5'b10000,1,6));
        vecs.push_back(mk(0,0,0,0,1,5'b00001,1,7));
        vecs.push_back(mk(0,0,0,0,0,5'b00010,1,7));
        vecs.push_back(mk(0,0,0,0,0,5'b00100,1,7));
        repeat (4) @(posedge clk);
        #1;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_icount", 32'(icount), 32'd0);
        chk("rst_phase_manual", 32'(phase0), 32'd0);
        @(negedge clk);
        n_rst = 1;
        wait_start("auto_start");
        chk("manual_idle_phase", 32'(phase0), 32'd0);
        chk("manual_idle_running", 32'(run0), 32'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            hlt = vecs[i].hlt; go = vecs[i].go; step_mode = vecs[i].step;
            stall = vecs[i].stall; fin = vecs[i].fin;
            e.idx = i; e.ph = vecs[i].ph; e.run = vecs[i].run; e.cnt = vecs[i].cnt;
            e.cyc = vecs[i].ph[0] & ~vecs[i].stall;
            sb.push_back(e);
        end
        @(negedge clk);
        hlt = 0; go = 0; step_mode = 0; stall = 0; fin = 0;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("pre_rst_phase", 32'(phase), 32'b00100);
        #2;
        n_rst = 0;
        #1;
        chk("async_rst_phase", 32'(phase), 32'd0);
        chk("async_rst_icount", 32'(icount), 32'd0);
        chk("async_rst_running", 32'(running), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1;
        wait_start("restart");
        chk("restart_icount", 32'(icount), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("manual_wait_phase", 32'(phase0), 32'd0);
        chk("manual_wait_running", 32'(run0), 32'd0);
        @(negedge clk);
        go0 = 1;
        @(posedge clk); #1;
        chk("manual_go_phase", 32'(phase0), 32'd1);
        chk("manual_go_running", 32'(run0), 32'd1);
        chk("manual_go_cyc_start", 32'(cyc0), 32'd1);
        @(negedge clk);
        go0 = 0;
        @(posedge clk); #1;
        chk("manual_advance", 32'(phase0), 32'b00010);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
